// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter and its watchdog.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK_IF = 2'd1,
        LOCK_DM = 2'd2
    } arb_state_t;

    // Fetch is always a plain word read.
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    localparam int CNT_W = 16;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Transaction watchdog: counts cycles a forwarded request has waited without
// an ack and flags expiry once the count reaches TIMEOUT-1.
module mem_arb_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // >= keeps TIMEOUT=1 from never firing, since the grant cycle already counts.
    assign o_expire = (r_count >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and stage_mem.
// Define MEM_ARB_RR_EN for round-robin conflicts; otherwise data always wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic        if_error,
    input  logic        dm_req,
    input  logic [31:0] dm_addr,
    input  logic        dm_write,
    input  logic [31:0] dm_data_out,
    input  logic        dm_extend,
    input  logic [1:0]  dm_width,
    output logic        dm_ack,
    output logic        dm_error,
    output logic [31:0] data_in,
    output logic        req,
    output logic [31:0] addr,
    output logic        write,
    output logic [31:0] data_out,
    output logic        extend,
    output logic [1:0]  width,
    input  logic        ack,
    input  logic        error,
    input  logic [31:0] mem_data_in,
    output logic [1:0]  owner
);

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    owner_t     r_last_owner;
    owner_t     w_winner;
    owner_t     w_owner;
    logic       w_wd_expire;
    logic       w_expire;
    logic       w_done;
    logic       w_wd_run;

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a signal unassigned and infers a latch.
    always_comb begin
        w_winner = OWN_NONE;
        if (if_req && dm_req) begin
            w_winner = (RR_EN && r_last_owner == OWN_DM) ? OWN_IF : OWN_DM;
        end else if (if_req) begin
            w_winner = OWN_IF;
        end else if (dm_req) begin
            w_winner = OWN_DM;
        end
    end

    // Reset gates ownership combinationally so the memory port drops at once.
    always_comb begin
        w_owner = OWN_NONE;
        if (reset_n) begin
            case (r_state)
                IDLE:    w_owner = w_winner;
                LOCK_IF: w_owner = if_req ? OWN_IF : OWN_NONE;
                LOCK_DM: w_owner = dm_req ? OWN_DM : OWN_NONE;
                default: w_owner = OWN_NONE;
            endcase
        end
    end

    assign w_expire = (r_state != IDLE) && (w_owner != OWN_NONE) && w_wd_expire && !ack;
    assign w_done   = ack || w_expire;
    assign w_wd_run = (w_owner != OWN_NONE) && !w_done;

    // Any forwarded request left open locks to its owner; ack, expiry or abort end it.
    always_comb begin
        w_state_nxt = IDLE;
        if (w_owner != OWN_NONE && !w_done) begin
            w_state_nxt = (w_owner == OWN_IF) ? LOCK_IF : LOCK_DM;
        end
    end

    // r_last_owner resets to fetch so data wins the first conflict in both modes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_owner <= OWN_IF;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_owner != OWN_NONE) begin
                r_last_owner <= w_owner;
            end
        end
    end

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  (!w_wd_run),
        .i_enable (w_wd_run),
        .o_expire (w_wd_expire)
    );

    always_comb begin
        req      = 1'b0;
        addr     = '0;
        write    = 1'b0;
        data_out = '0;
        extend   = 1'b0;
        width    = '0;
        if_ack   = 1'b0;
        if_error = 1'b0;
        dm_ack   = 1'b0;
        dm_error = 1'b0;
        data_in  = '0;
        case (w_owner)
            OWN_IF: begin
                req      = 1'b1;
                addr     = if_addr;
                width    = WIDTH_WORD;
                if_ack   = w_done;
                if_error = ack ? error : w_expire;
                data_in  = mem_data_in;
            end
            OWN_DM: begin
                req      = 1'b1;
                addr     = dm_addr;
                write    = dm_write;
                data_out = dm_data_out;
                extend   = dm_extend;
                width    = dm_width;
                dm_ack   = w_done;
                dm_error = ack ? error : w_expire;
                data_in  = mem_data_in;
            end
            default: ;
        endcase
    end

    assign owner = w_owner;

endmodule
